// File: rtl/compat_totd_ctrl_pkg.sv
// Shared definitions for the 40 MHz compatibility ToTd sequencer: default widths,
// configuration-request FSM states and the 3-phase ENABLE40 step function.
package compat_totd_ctrl_pkg;

   localparam int ADC_W_DEF       = 12;
   localparam int OCC_W_DEF       = 7;
   localparam int FD_W_DEF        = 12;
   localparam int FN_W_DEF        = 12;
   localparam int INT_W_DEF       = 17;
   localparam int FLUSH_TICKS_DEF = 128;
   localparam int DEAD_W          = 16;
   localparam int MISSED_W        = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_APPLY = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } cfg_state_e;

   // A realign always lands on phase 0; otherwise count 0,1,2,0,...
   function automatic logic [1:0] phase_next(input logic [1:0] phase, input logic sync);
      if (sync || phase == 2'd2) begin
         return 2'd0;
      end
      return phase + 2'd1;
   endfunction

endpackage

// File: rtl/compat_totd_ctrl_phase_gen.sv
// ENABLE40 phase counter derived from CLK120, with SYNC40 realign; TICK40 marks phase 0.
module compat_totd_ctrl_phase_gen
   import compat_totd_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sync40_i,
   output logic [1:0] enable40_o,
   output logic       tick40_o
);

   logic [1:0] phase_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q <= 2'd0;
      end else begin
         phase_q <= phase_next(phase_q, sync40_i);
      end
   end

   assign enable40_o = phase_q;
   assign tick40_o   = (phase_q == 2'd0);

endmodule

// File: rtl/compat_totd_ctrl.sv
// Config sequencer and trigger dead-time gate between the register bank and totd_40mhz:
// atomic config apply on a safe phase, post-apply trigger mask, dead time and missed count.
module compat_totd_ctrl
   import compat_totd_ctrl_pkg::*;
#(
   parameter int ADC_W       = ADC_W_DEF,
   parameter int OCC_W       = OCC_W_DEF,
   parameter int FD_W        = FD_W_DEF,
   parameter int FN_W        = FN_W_DEF,
   parameter int INT_W       = INT_W_DEF,
   parameter int FLUSH_TICKS = FLUSH_TICKS_DEF
)
(
   input  logic                clk120_i,
   input  logic                rst_i,
   input  logic                sync40_i,
   input  logic                cfg_req_i,
   input  logic [3*ADC_W-1:0]  cfg_thres_i,
   input  logic [3*ADC_W-1:0]  cfg_up_i,
   input  logic [2:0]          cfg_trig_en_i,
   input  logic [1:0]          cfg_mult_i,
   input  logic [OCC_W-1:0]    cfg_occ_i,
   input  logic [FD_W-1:0]     cfg_fd_i,
   input  logic [FN_W-1:0]     cfg_fn_i,
   input  logic [INT_W-1:0]    cfg_int_i,
   input  logic [DEAD_W-1:0]   deadtime_i,
   input  logic                missed_clr_i,
   input  logic                trig_i,
   output logic [1:0]          enable40_o,
   output logic [3*ADC_W-1:0]  act_thres_o,
   output logic [3*ADC_W-1:0]  act_up_o,
   output logic [2:0]          act_trig_en_o,
   output logic [1:0]          act_mult_o,
   output logic [OCC_W-1:0]    act_occ_o,
   output logic [FD_W-1:0]     act_fd_o,
   output logic [FN_W-1:0]     act_fn_o,
   output logic [INT_W-1:0]    act_int_o,
   output logic                cfg_busy_o,
   output logic                cfg_ack_o,
   output logic                cfg_ovr_o,
   output logic                trig_o,
   output logic [MISSED_W-1:0] missed_o
);

   localparam int FL_W = $clog2(FLUSH_TICKS + 1);

   logic [1:0]          enable40;
   logic                tick40;
   cfg_state_e          state_q;
   logic [FL_W-1:0]     flush_q;
   logic                busy_q, ack_q, ovr_q;
   logic [3*ADC_W-1:0]  stg_thres_q, stg_up_q, act_thres_q, act_up_q;
   logic [2:0]          stg_en_q, act_en_q;
   logic [1:0]          stg_mult_q, act_mult_q;
   logic [OCC_W-1:0]    stg_occ_q, act_occ_q;
   logic [FD_W-1:0]     stg_fd_q, act_fd_q;
   logic [FN_W-1:0]     stg_fn_q, act_fn_q;
   logic [INT_W-1:0]    stg_int_q, act_int_q;
   logic [DEAD_W-1:0]   dead_q;
   logic [MISSED_W-1:0] missed_q;
   logic                trig_d_q, trig_out_q;
   logic                masked, trig_edge, trig_blocked;

   compat_totd_ctrl_phase_gen u_phase_gen (
      .clk_i      (clk120_i),
      .rst_i      (rst_i),
      .sync40_i   (sync40_i),
      .enable40_o (enable40),
      .tick40_o   (tick40)
   );

   // The datapath window still holds samples judged under the old config while masked.
   assign masked       = (state_q == ST_APPLY) || (state_q == ST_FLUSH);
   assign trig_edge    = trig_i & ~trig_d_q;
   assign trig_blocked = masked || (dead_q != '0);

   always_ff @(posedge clk120_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         flush_q     <= '0;
         busy_q      <= 1'b0;
         ack_q       <= 1'b0;
         ovr_q       <= 1'b0;
         stg_thres_q <= '0; stg_up_q <= '0; stg_en_q <= '0; stg_mult_q <= '0;
         stg_occ_q   <= '0; stg_fd_q <= '0; stg_fn_q <= '0; stg_int_q  <= '0;
         act_thres_q <= '0; act_up_q <= '0; act_en_q <= '0; act_mult_q <= '0;
         act_occ_q   <= '0; act_fd_q <= '0; act_fn_q <= '0; act_int_q  <= '0;
      end else begin
         ack_q <= 1'b0;
         ovr_q <= cfg_req_i && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (cfg_req_i) begin
                  stg_thres_q <= cfg_thres_i; stg_up_q <= cfg_up_i;
                  stg_en_q    <= cfg_trig_en_i; stg_mult_q <= cfg_mult_i;
                  stg_occ_q   <= cfg_occ_i; stg_fd_q <= cfg_fd_i;
                  stg_fn_q    <= cfg_fn_i; stg_int_q <= cfg_int_i;
                  busy_q      <= 1'b1;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Phase 2 is the last 120 MHz cycle of a 40 MHz period: safe swap point.
               if (enable40 == 2'd2 && dead_q == '0) begin
                  state_q <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               act_thres_q <= stg_thres_q; act_up_q <= stg_up_q;
               act_en_q    <= stg_en_q; act_mult_q <= stg_mult_q;
               act_occ_q   <= stg_occ_q; act_fd_q <= stg_fd_q;
               act_fn_q    <= stg_fn_q; act_int_q <= stg_int_q;
               flush_q     <= FL_W'(FLUSH_TICKS);
               state_q     <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (flush_q == '0) begin
                  busy_q  <= 1'b0;
                  ack_q   <= 1'b1;
                  state_q <= ST_DONE;
               end else if (tick40) begin
                  flush_q <= flush_q - 1'b1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk120_i) begin
      if (rst_i) begin
         trig_d_q   <= 1'b0;
         trig_out_q <= 1'b0;
         dead_q     <= '0;
         missed_q   <= '0;
      end else begin
         trig_d_q   <= trig_i;
         trig_out_q <= trig_edge && !trig_blocked;
         if (trig_edge && !trig_blocked) begin
            dead_q <= deadtime_i;
         end else if (tick40 && dead_q != '0) begin
            dead_q <= dead_q - 1'b1;
         end
         if (missed_clr_i) begin
            missed_q <= MISSED_W'(trig_edge && trig_blocked);
         end else if (trig_edge && trig_blocked && missed_q != '1) begin
            missed_q <= missed_q + 1'b1;
         end
      end
   end

   assign enable40_o    = enable40;
   assign act_thres_o   = act_thres_q;
   assign act_up_o      = act_up_q;
   assign act_trig_en_o = act_en_q;
   assign act_mult_o    = masked ? 2'd0 : act_mult_q;
   assign act_occ_o     = act_occ_q;
   assign act_fd_o      = act_fd_q;
   assign act_fn_o      = act_fn_q;
   assign act_int_o     = act_int_q;
   assign cfg_busy_o    = busy_q;
   assign cfg_ack_o     = ack_q;
   assign cfg_ovr_o     = ovr_q;
   assign trig_o        = trig_out_q;
   assign missed_o      = missed_q;

endmodule

// File: tb/tb_compat_totd_ctrl.sv
// Scoreboard bench for compat_totd_ctrl: a behavioural model predicts pulse events into
// queues and per-cycle state; a monitor pops and compares after each rising edge.
module tb_compat_totd_ctrl;

   localparam int FLUSH = 128;

   typedef struct packed {
      logic [35:0] thres;
      logic [35:0] up;
      logic [2:0]  en;
      logic [1:0]  mult;
      logic [6:0]  occ;
      logic [11:0] fd;
      logic [11:0] fn;
      logic [16:0] intg;
   } cfg_t;

   logic        clk = 1'b0, rst = 1'b1, sync40 = 1'b0, cfg_req = 1'b0;
   logic        missed_clr = 1'b0, trig = 1'b0;
   logic [15:0] deadtime = '0;
   cfg_t        cfg_in = '0;

   logic [1:0]  enable40, act_mult, act_en;
   logic [35:0] act_thres, act_up;
   logic [6:0]  act_occ;
   logic [11:0] act_fd, act_fn;
   logic [16:0] act_int;
   logic        busy, ack, ovr, trig_out;
   logic [15:0] missed;
   logic [2:0]  act_en3;

   compat_totd_ctrl dut (
      .clk120_i(clk), .rst_i(rst), .sync40_i(sync40), .cfg_req_i(cfg_req),
      .cfg_thres_i(cfg_in.thres), .cfg_up_i(cfg_in.up), .cfg_trig_en_i(cfg_in.en),
      .cfg_mult_i(cfg_in.mult), .cfg_occ_i(cfg_in.occ), .cfg_fd_i(cfg_in.fd),
      .cfg_fn_i(cfg_in.fn), .cfg_int_i(cfg_in.intg), .deadtime_i(deadtime),
      .missed_clr_i(missed_clr), .trig_i(trig), .enable40_o(enable40),
      .act_thres_o(act_thres), .act_up_o(act_up), .act_trig_en_o(act_en3),
      .act_mult_o(act_mult), .act_occ_o(act_occ), .act_fd_o(act_fd), .act_fn_o(act_fn),
      .act_int_o(act_int), .cfg_busy_o(busy), .cfg_ack_o(ack), .cfg_ovr_o(ovr),
      .trig_o(trig_out), .missed_o(missed)
   );

   assign act_en = act_en3[1:0];

   always #5 clk = ~clk;

   int n_checks = 0, n_fail = 0, cyc = 0;
   int q_ev[3][$];   // expected pulse cycles: 0 trig_o, 1 cfg_ack_o, 2 cfg_ovr_o

   // Reference model: state describes the current cycle's outputs.
   int   m_ph = 0, m_dead = 0, m_missed = 0, m_seen = 0;
   bit   m_busy = 0, m_wait = 0, m_apply = 0, m_flush = 0, m_ack = 0, m_prev = 0;
   cfg_t m_stage = '0, m_act = '0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_dead = 0; m_missed = 0; m_seen = 0;
      m_busy = 0; m_wait = 0; m_apply = 0; m_flush = 0; m_ack = 0; m_prev = 0;
      m_stage = '0; m_act = '0;
   endtask

   task automatic model_step();
      bit tck, edge_s, blk, acc, idle;
      if (rst) begin
         model_reset();
         return;
      end
      tck    = (m_ph == 0);
      edge_s = trig && !m_prev;
      blk    = (m_dead != 0) || m_apply || m_flush;
      acc    = edge_s && !blk;
      idle   = !m_busy && !m_ack;
      if (acc) q_ev[0].push_back(cyc + 1);
      if (cfg_req && !idle) q_ev[2].push_back(cyc + 1);
      if (missed_clr) m_missed = (edge_s && blk) ? 1 : 0;
      else if (edge_s && blk && m_missed < 65535) m_missed++;
      if (m_ack) m_ack = 0;
      else if (idle) begin
         if (cfg_req) begin m_stage = cfg_in; m_busy = 1; m_wait = 1; end
      end else if (m_wait) begin
         if (m_ph == 2 && m_dead == 0) begin m_wait = 0; m_apply = 1; end
      end else if (m_apply) begin
         m_act = m_stage; m_apply = 0; m_flush = 1; m_seen = 0;
      end else if (m_flush) begin
         if (m_seen == FLUSH) begin
            m_flush = 0; m_busy = 0; m_ack = 1; q_ev[1].push_back(cyc + 1);
         end else if (tck) m_seen++;
      end
      if (acc) m_dead = int'(deadtime);
      else if (tck && m_dead > 0) m_dead--;
      m_prev = trig;
      m_ph   = sync40 ? 0 : (m_ph + 1) % 3;
   endtask

   function automatic cfg_t rand_cfg();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      return r[124:0];
   endfunction

   // Monitor: compares DUT outputs against the model just after every rising edge.
   initial begin
      string names [3];
      logic  seen  [3];
      int    exp_c;
      names = '{"trig_o", "cfg_ack_o", "cfg_ovr_o"};
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         seen = '{trig_out, ack, ovr};
         chk("enable40", 128'(enable40), 128'(m_ph));
         chk("cfg_busy", 128'(busy), 128'(m_busy));
         chk("act_mult", 128'(act_mult), 128'((m_apply || m_flush) ? 2'd0 : m_act.mult));
         chk("act_cfg", 128'({act_thres, act_up, act_en3, act_occ, act_fd, act_fn, act_int}),
             128'({m_act.thres, m_act.up, m_act.en, m_act.occ, m_act.fd, m_act.fn, m_act.intg}));
         chk("missed", 128'(missed), 128'(m_missed));
         for (int k = 0; k < 3; k++) begin
            while (q_ev[k].size() > 0 && q_ev[k][0] < cyc) begin
               n_checks++; n_fail++;
               $display("FAIL %s missing: got none expected pulse at cycle %0d", names[k], q_ev[k][0]);
               void'(q_ev[k].pop_front());
            end
            if (seen[k]) begin
               if (q_ev[k].size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL %s unexpected: got pulse at cycle %0d expected none", names[k], cyc);
               end else begin
                  exp_c = q_ev[k].pop_front();
                  chk(names[k], 128'(cyc), 128'(exp_c));
               end
            end
         end
      end
   end

   task automatic tick();
      model_step();
      @(negedge clk);
      cfg_req = 1'b0; sync40 = 1'b0; missed_clr = 1'b0;
   endtask

   task automatic pulse_trig();
      trig = 1'b1; tick();
      trig = 1'b0; tick();
   endtask

   task automatic wait_ack(input int limit);
      for (int i = 0; i < limit && !m_ack; i++) tick();
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit && (m_busy || m_ack); i++) tick();
   endtask

   initial begin
      cfg_in = rand_cfg();
      @(negedge clk);
      repeat (4) tick();
      rst = 1'b0;
      repeat (7) tick();

      // Realign on a phase-1 cycle.
      for (int i = 0; i < 3 && m_ph != 1; i++) tick();
      sync40 = 1'b1; tick();
      repeat (4) tick();

      // Config apply: THRES0 = 0x100, MULT = 2.
      cfg_in = rand_cfg(); cfg_in.thres[11:0] = 12'h100; cfg_in.mult = 2'd2;
      cfg_req = 1'b1; tick();
      cfg_in = rand_cfg();
      wait_ack(600);
      repeat (3) tick();

      // Dead time of 10 ticks: accepted, blocked after ~5 ticks, accepted after expiry.
      deadtime = 16'd10;
      pulse_trig();
      repeat (13) tick();
      pulse_trig();
      repeat (20) tick();
      pulse_trig();
      repeat (4) tick();

      // Overlapping request while busy.
      wait_idle(600);
      cfg_in = rand_cfg(); cfg_req = 1'b1; tick();
      cfg_in = rand_cfg(); repeat (20) tick();
      cfg_req = 1'b1; tick();
      cfg_in = rand_cfg();
      wait_ack(600);
      repeat (3) tick();

      // MISSED saturation and clear-with-edge.
      for (int i = 0; i < 200 && (m_dead != 0 || m_apply || m_flush); i++) tick();
      deadtime = 16'd1000;
      pulse_trig();
      force dut.missed_q = 16'hFFFD;
      m_missed = 65533;
      #1;
      release dut.missed_q;
      repeat (4) pulse_trig();
      trig = 1'b1; missed_clr = 1'b1; tick();
      trig = 1'b0; tick();
      missed_clr = 1'b1; tick();
      tick();
      rst = 1'b1; tick(); tick();
      rst = 1'b0; deadtime = '0; tick();

      // Reset in the middle of the flush window, then a clean request.
      cfg_in = rand_cfg(); cfg_req = 1'b1; tick();
      for (int i = 0; i < 50 && !m_flush; i++) tick();
      repeat (60) tick();
      rst = 1'b1; tick(); tick();
      rst = 1'b0; tick();
      cfg_in = rand_cfg(); cfg_req = 1'b1; tick();
      wait_ack(600);
      repeat (3) tick();

      // Randomised traffic.
      for (int n = 0; n < 4000; n++) begin
         trig       = ($urandom_range(0, 2) == 0);
         sync40     = ($urandom_range(0, 99) == 0);
         cfg_req    = ($urandom_range(0, 149) == 0);
         missed_clr = ($urandom_range(0, 199) == 0);
         rst        = ($urandom_range(0, 1999) == 0);
         deadtime   = 16'($urandom_range(0, 12));
         cfg_in     = rand_cfg();
         tick();
      end
      rst = 1'b0; trig = 1'b0;
      repeat (5) tick();

      chk("trig_queue_empty", 128'(q_ev[0].size()), 128'(0));
      chk("ack_queue_empty", 128'(q_ev[1].size()), 128'(0));
      chk("ovr_queue_empty", 128'(q_ev[2].size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
